wash_panel: RTL and testbench
=============================

# wash_panel

Front-panel input conditioner for the washer controller. It synchronizes and debounces the power switch and three push-buttons. It turns those inputs into the level and single-cycle pulse signals the washer controller consumes: `on`, `mode`, `m_pos` and `u_pos`. It also consumes the controller's `nxt` completion pulse to track the wash cycle, so it can lock the mode selector and gate button pulses.

## Interface
Parameters:
- `DEB_CYCLES`, default 2_000_000, is the number of consecutive stable cycles required to accept a level change (20 ms at 100 MHz). Legal minimum is 2.

Ports:
- `clk`: input, 1 bit, system clock (100 MHz).
- `rst`: input, 1 bit. Reset is synchronous, active-high.
- `sw_on`: input, 1 bit, raw power slide switch, asynchronous.
- `btn_start`: input, 1 bit, raw start button, active-high, asynchronous.
- `btn_mode`: input, 1 bit, raw mode-select button, active-high, asynchronous.
- `btn_alert`: input, 1 bit, raw alert/door button, active-high, asynchronous.
- `nxt`: input, 1 bit, one-cycle completion pulse from the washer controller.
- `on`: output, 1 bit, debounced power level.
- `mode`: output, 2 bits. 00 = spin-dry, 01 = small, 10 = medium, 11 = large.
- `m_pos`: output, 1 bit, one-cycle start pulse.
- `u_pos`: output, 1 bit, one-cycle alert pulse.
- `busy`: output, 1 bit, high while a wash cycle is running.
- `done`: output, 1 bit, high from completion until acknowledged.
- `mode_led`: output, 4 bits, one-hot display of `mode` (bit i is high when `mode == i`).

## Operation
- **Per-input front end (4 instances):**
  - 2-FF synchronizer, then a debounce counter, then a `stable` register.
  - The counter clears whenever the synchronized value equals `stable`.
  - Otherwise the counter increments. When it reaches `DEB_CYCLES-1`, `stable` takes the synchronized value and the counter clears.
  - The counter width is `$clog2(DEB_CYCLES)`. It never wraps.
- **Press events:**
  - A press is a 0→1 transition of a button's `stable` signal, lasting one cycle.
  - Releases generate no event.
- **`on`:** equals the `stable` value of `sw_on`.
- **FSM states:** IDLE, RUN, DONE.
  - **IDLE:**
    - A mode press increments `mode`, wrapping 11→00.
    - A start press while `on=1` asserts `m_pos` for one cycle and moves to RUN.
    - Alert presses are dropped.
    - A start press while `on=0` is dropped.
  - **RUN:**
    - `busy=1`.
    - `mode` is frozen and mode presses are dropped.
    - An alert press asserts `u_pos` for one cycle.
    - Start presses are dropped.
    - `nxt=1` moves to DONE.
  - **DONE:**
    - `done=1`, `mode` frozen.
    - Any press (start, mode or alert) moves to IDLE. That press is consumed and has no other effect.
    - `nxt` is ignored.
- **Power-off:** `on=0` in RUN or DONE forces IDLE on the next edge. No pulses are emitted and `mode` is kept.
- **Simultaneous events:**
  - Start and mode pressed in the same cycle in IDLE: start wins, `mode` is unchanged, `m_pos` is asserted.
  - `nxt` and alert in the same cycle in RUN: `u_pos` is asserted and the state moves to DONE.
  - `on` falling in the same cycle as `nxt`: the state goes to IDLE.
- `nxt` in IDLE is ignored.

## Timing
- **Reset values:**
  - State IDLE.
  - `on=0`, `mode=2'b11`, `mode_led=4'b1000`.
  - `m_pos=0`, `u_pos=0`, `busy=0`, `done=0`.
  - Synchronizers, counters and `stable` all cleared.
- Reset mid-cycle aborts RUN or DONE without pulses. A button held through reset produces one press once it is debounced.
- **Latency:**
  - A raw level that changes before clock edge k and then holds shows up at `stable` after edge k+1+`DEB_CYCLES`.
  - The resulting `m_pos`/`u_pos` pulse, the `mode` update or the state change is registered one edge later, at k+2+`DEB_CYCLES`.
- A glitch shorter than `DEB_CYCLES` synchronized cycles produces no change.
- `busy` and `done` are registered decodes of the state and change on the same edge as the state.
- `m_pos` and `u_pos` are registered, high for exactly one cycle per accepted press, and never high in the same cycle as each other.
- `nxt` is sampled directly without synchronization, since it shares `clk`. The state moves to DONE on the edge where `nxt=1`.
- The `mode_led` update is registered on the same edge as `mode`.

## Test plan
All scenarios use `DEB_CYCLES=4`.
1. **Reset and power:**
   - Hold `rst` for 2 cycles, then set `sw_on=1`.
   - Required: `mode=11`, `mode_led=1000`, no pulses; `on` rises 6 edges after `sw_on` and the start press asserts `m_pos` on edge k+6.
2. **Debounce:**
   - With `on=1` in IDLE, give `btn_mode` a 3-cycle glitch and then a 10-cycle press.
   - Required: the glitch causes no change; the press wraps `mode` from 11 to 00 (`mode_led=0001`) exactly once, and the release causes nothing.
3. **Full cycle:**
   - In IDLE with `mode=01`, press start. Then press mode, press alert, then pulse `nxt`. Then press alert.
   - Required:
     - One `m_pos` and `busy=1`.
     - `mode` stays 01 through the mode press.
     - One `u_pos` for the first alert.
     - DONE with `done=1`.
     - The second alert returns the block to IDLE with `u_pos` kept at 0.
4. **Simultaneous presses:**
   - Start and mode rise in the same cycle in IDLE.
   - Required: `m_pos` pulses, `mode` is unchanged, the state goes to RUN.
5. **Power-off mid-run:**
   - In RUN, set `sw_on=0`.
   - Required: `busy` drops 6 edges later with no `u_pos`/`m_pos`, and `mode` is retained. With `on=0`, a start press yields no `m_pos`.
6. **Reset mid-run:**
   - Assert `rst` in RUN while `btn_alert` is held.
   - Required: all outputs return to their reset values, then exactly one `u_pos`-free press event is handled in IDLE (dropped), and the state stays IDLE.

Source files
------------

// File: rtl/wash_panel.sv
// wash_panel: synchronizes and debounces the power switch and panel buttons, and
// tracks the wash cycle to gate start/alert pulses and freeze the mode selector.
module wash_panel #(
  parameter int DEB_CYCLES = 2_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sw_on,
  input  logic       btn_start,
  input  logic       btn_mode,
  input  logic       btn_alert,
  input  logic       nxt,
  output logic       on,
  output logic [1:0] mode,
  output logic       m_pos,
  output logic       u_pos,
  output logic       busy,
  output logic       done,
  output logic [3:0] mode_led
);
  localparam int CW = $clog2(DEB_CYCLES);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [3:0] raw, sync1_q, sync2_q, stable_q, stable_d, rise_q, rise_d, hit;
  logic [CW-1:0] cnt_q [4];
  logic [CW-1:0] cnt_d [4];
  logic [1:0] mode_q, mode_d;
  logic [3:0] mode_led_q, mode_led_d;
  logic m_pos_q, m_pos_d, u_pos_q, u_pos_d, busy_q, busy_d, done_q, done_d;
  logic start_p, mode_p, alert_p;
  assign raw = {btn_alert, btn_mode, btn_start, sw_on};
  assign on = stable_q[0];
  assign start_p = rise_q[1];
  assign mode_p = rise_q[2];
  assign alert_p = rise_q[3];
  assign mode = mode_q;
  assign mode_led = mode_led_q;
  assign m_pos = m_pos_q;
  assign u_pos = u_pos_q;
  assign busy = busy_q;
  assign done = done_q;
  // A level is accepted only after DEB_CYCLES consecutive mismatching samples.
  always_comb begin
    hit = '0;
    stable_d = stable_q;
    rise_d = '0;
    for (int i = 0; i < 4; i++) begin
      hit[i] = (sync2_q[i] != stable_q[i]) && (cnt_q[i] == CW'(DEB_CYCLES - 1));
      cnt_d[i] = (sync2_q[i] == stable_q[i] || hit[i]) ? '0 : cnt_q[i] + CW'(1);
      stable_d[i] = hit[i] ? sync2_q[i] : stable_q[i];
      rise_d[i] = hit[i] & sync2_q[i];
    end
  end
  always_comb begin
    state_d = state_q;
    mode_d = mode_q;
    m_pos_d = 1'b0;
    u_pos_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_p && on) begin
          state_d = RUN;
          m_pos_d = 1'b1;
        end else if (mode_p) begin
          mode_d = mode_q + 2'd1;
        end
      end
      RUN: begin
        u_pos_d = on & alert_p;
        state_d = !on ? IDLE : (nxt ? DONE : RUN);
      end
      DONE: state_d = (!on || start_p || mode_p || alert_p) ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
    mode_led_d = 4'b0001 << mode_d;
    busy_d = state_d == RUN;
    done_d = state_d == DONE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      stable_q <= '0;
      rise_q <= '0;
      cnt_q <= '{default: '0};
      state_q <= IDLE;
      mode_q <= 2'b11;
      mode_led_q <= 4'b1000;
      m_pos_q <= 1'b0;
      u_pos_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      stable_q <= stable_d;
      rise_q <= rise_d;
      cnt_q <= cnt_d;
      state_q <= state_d;
      mode_q <= mode_d;
      mode_led_q <= mode_led_d;
      m_pos_q <= m_pos_d;
      u_pos_q <= u_pos_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end
endmodule

// File: tb/tb_wash_panel.sv
// tb_wash_panel: directed panel scenarios with literal checks plus randomized stimulus
// checked every cycle against a window-based behavioural model.
module tb_wash_panel;
  localparam int DEB = 4;
  logic clk = 1'b0, rst = 1'b1;
  logic sw_on = 0, btn_start = 0, btn_mode = 0, btn_alert = 0, nxt = 0;
  logic on, m_pos, u_pos, busy, done;
  logic [1:0] mode;
  logic [3:0] mode_led;
  int n_cmp = 0, n_bad = 0;
  wash_panel #(.DEB_CYCLES(DEB)) dut (
    .clk(clk), .rst(rst), .sw_on(sw_on), .btn_start(btn_start), .btn_mode(btn_mode),
    .btn_alert(btn_alert), .nxt(nxt), .on(on), .mode(mode), .m_pos(m_pos), .u_pos(u_pos),
    .busy(busy), .done(done), .mode_led(mode_led)
  );
  always #5 clk = ~clk;
  // Model: a stable level flips once the last DEB synchronized samples all differ from it.
  bit [DEB:0] h [4];
  bit [3:0] stab, rise;
  int st;
  bit [1:0] md;
  bit mp, up, en;
  always @(posedge clk) begin
    bit [3:0] r;
    bit flip, pwr;
    r = {btn_alert, btn_mode, btn_start, sw_on};
    if (rst) begin
      for (int i = 0; i < 4; i++) h[i] = '0;
      stab = 0; rise = 0; st = 0; md = 2'd3; mp = 0; up = 0; en = 1;
    end else begin
      pwr = stab[0];
      mp = 0; up = 0;
      if (st == 0) begin
        if (rise[1] && pwr) begin st = 1; mp = 1; end
        else if (rise[2]) md = md + 2'd1;
      end else if (!pwr) st = 0;
      else if (st == 1) begin up = rise[3]; if (nxt) st = 2; end
      else if (rise[1] || rise[2] || rise[3]) st = 0;
      for (int i = 0; i < 4; i++) begin
        flip = 1;
        for (int j = 1; j <= DEB; j++) if (h[i][j] == stab[i]) flip = 0;
        rise[i] = flip && !stab[i];
        if (flip) stab[i] = !stab[i];
        h[i] = {h[i][DEB-1:0], r[i]};
      end
    end
  end
  always @(negedge clk) begin
    logic [10:0] act, exp;
    if (en) begin
      act = {on, mode, m_pos, u_pos, busy, done, mode_led};
      exp = {stab[0], md, mp, up, st == 1, st == 2, 4'b0001 << md};
      n_cmp++;
      if (act !== exp) begin
        n_bad++;
        $display("FAIL model t=%0t got on,mode,m,u,busy,done,led=%b want %b", $time, act, exp);
      end
    end
  end
  task automatic step(int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask
  task automatic lit(string name, logic [3:0] act, logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0t got %b want %b", name, $time, act, exp);
    end
  endtask
  task automatic hold_release(int which);
    case (which)
      1: btn_start = 1;
      2: btn_mode = 1;
      default: btn_alert = 1;
    endcase
    step(8);
    btn_start = 0; btn_mode = 0; btn_alert = 0;
    step(10);
  endtask
  initial begin
    step(2);
    rst = 0;
    lit("reset_mode", 4'(mode), 4'd3);
    lit("reset_led", mode_led, 4'b1000);
    lit("reset_out", {on, m_pos, u_pos, busy}, 4'b0000);
    sw_on = 1;
    step(5); lit("on_early", 4'(on), 4'd0);
    step(1); lit("on_rise", 4'(on), 4'd1);
    btn_mode = 1; step(3); btn_mode = 0; step(12);
    lit("glitch_mode", 4'(mode), 4'd3);
    btn_mode = 1; step(10); btn_mode = 0; step(12);
    lit("wrap_mode", 4'(mode), 4'd0);
    lit("wrap_led", mode_led, 4'b0001);
    hold_release(2);
    lit("mode_small", 4'(mode), 4'd1);
    btn_start = 1;
    step(6); lit("m_pos_early", 4'(m_pos), 4'd0);
    step(1); lit("m_pos", 4'(m_pos), 4'd1); lit("busy_run", 4'(busy), 4'd1);
    step(1); lit("m_pos_once", 4'(m_pos), 4'd0);
    btn_start = 0; step(10);
    hold_release(2);
    lit("mode_frozen", 4'(mode), 4'd1);
    btn_alert = 1; step(7); lit("u_pos", 4'(u_pos), 4'd1);
    btn_alert = 0; step(10);
    nxt = 1; step(1); nxt = 0;
    lit("done_state", {2'b0, busy, done}, 4'b0001);
    hold_release(3);
    lit("done_ack", {2'b0, busy, done}, 4'b0000);
    btn_start = 1; btn_mode = 1; step(7);
    lit("simul_mpos", 4'(m_pos), 4'd1);
    lit("simul_mode", 4'(mode), 4'd1);
    btn_start = 0; btn_mode = 0; step(10);
    sw_on = 0;
    step(6); lit("off_busy_hold", 4'(busy), 4'd1);
    step(1); lit("off_busy_drop", 4'(busy), 4'd0); lit("off_mode", 4'(mode), 4'd1);
    hold_release(1);
    lit("off_no_start", 4'(busy), 4'd0);
    sw_on = 1; step(8);
    btn_start = 1; step(8); btn_start = 0; step(4);
    lit("run_again", 4'(busy), 4'd1);
    btn_alert = 1; step(2);
    rst = 1; step(2); rst = 0;
    lit("rst_mode", 4'(mode), 4'd3);
    lit("rst_out", {on, busy, done, u_pos}, 4'b0000);
    lit("rst_led", mode_led, 4'b1000);
    step(15);
    lit("rst_idle", {on, busy, done, u_pos}, 4'b1000);
    btn_alert = 0; step(10);
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(7) == 0) sw_on = ~sw_on;
      if ($urandom_range(7) == 0) btn_start = ~btn_start;
      if ($urandom_range(7) == 0) btn_mode = ~btn_mode;
      if ($urandom_range(7) == 0) btn_alert = ~btn_alert;
      if (sw_on == 0 && $urandom_range(3) == 0) sw_on = 1;
      nxt = ($urandom_range(7) == 0);
      rst = ($urandom_range(399) == 0);
      step(1);
    end
    rst = 0; nxt = 0;
    step(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
